ex_stage: RTL and testbench
===========================

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Parameter: MUL_EN, default 1, enables the iterative multiplier; when 0, I=15 yields result 0 in one cycle with no stall.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 reset_n  in  1  reset, synchronous, active-low.
REQ-004 ID/EX inputs, all driven from the ID/EX pipeline register:
- d_write_enable_EX, d_load_enable_EX, Iv_alu_EX, Pc_alu_EX, nullify  in  1
- I_EX, Rd_EX, Rs1_EX, Rs2_EX  in  5
- Iv_EX, S1_EX, S2_EX, PC_EX  in  32
REQ-005 Rd_WB  in  5  and  wb_data  in  32  are the writeback-stage destination and value.
REQ-006 pc_cmd_EX  out  1  signals a taken branch; pc_target_EX  out  32  is its target.
REQ-007 stall  out  1  holds the IF/ID/ID-EX registers while high.
REQ-008 EX/MEM register outputs:
- d_write_enable_MEM, d_load_enable_MEM  out  1
- Rd_MEM  out  5
- ALU_out_MEM, S2_MEM  out  32

Function
REQ-010 Forwarding, applied to Rs1 and Rs2 independently:
- fwd = ALU_out_MEM if Rd_MEM==Rs && Rs!=0;
- else wb_data if Rd_WB==Rs && Rs!=0;
- else S1_EX/S2_EX.
- MEM has priority over WB. Load-use hazards are removed by software.
REQ-011 Operand A = PC_EX if Pc_alu_EX, else fwd1. Operand B = Iv_EX if Iv_alu_EX, else fwd2.
REQ-012 I encoding:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR;
- 5 SLL, 6 SRL, 7 SRA, shift amount B[4:0];
- 8 SLT signed, 9 SLTU, 10 SEQ, 11 SNE, each producing 0/1;
- 12 BEQZ, 13 BNEZ, 14 J;
- 15 MUL;
- 16-31 result 0.
- All arithmetic is modulo 2^32.
REQ-013 Branches:
- BEQZ is taken if fwd1==0; BNEZ is taken if fwd1!=0; J is always taken.
- pc_target_EX = PC_EX + Iv_EX, combinational.
- ALU_out for a branch = PC_EX + 4.
REQ-014 Taken branch: pc_cmd_EX is combinational and is asserted only when nullify==0 and stall==0.
REQ-015 A valid instruction is one with nullify==0. A nullified instruction loads a bubble into EX/MEM: all outputs 0.
REQ-016 Non-MUL valid instruction, 1-cycle latency: at the next edge, EX/MEM takes Rd_EX, the result, fwd2 as S2_MEM, and both enables.
REQ-017 MUL FSM, states IDLE, BUSY and DONE:
- IDLE->BUSY when a valid I=15 is present; operands A and B are latched at that edge and cnt=0.
- BUSY runs a shift-add over 32 cycles; cnt increments each cycle; BUSY->DONE when cnt==31.
- DONE->IDLE unconditionally; EX/MEM captures the low 32 bits of the product at that edge.
REQ-018 stall = (IDLE && valid I==15 && MUL_EN) || BUSY. Stall is high for exactly 33 cycles per MUL and low in DONE.
REQ-019 While stall is high, EX/MEM loads a bubble each cycle, so no duplicate commit occurs.
REQ-020 If nullify rises while in BUSY, it is ignored: the held instruction was already accepted.
REQ-021 Multiplier result equals (A*B) mod 2^32 for all operands, including 0, 0xFFFFFFFF and 0x80000000.

Reset
REQ-030 When reset_n is low at a rising edge:
- all EX/MEM outputs are set to 0;
- FSM goes to IDLE and cnt=0;
- stall and pc_cmd_EX are 0 on the following cycle.
REQ-031 Reset during BUSY aborts the multiply with no commit.
REQ-032 After reset release, the first instruction is processed normally.

Verification
REQ-040 ADD, S1=5, S2=7, no hazards -> one cycle later ALU_out_MEM=12 and Rd_MEM=Rd_EX.
REQ-041 Rs1=3, Rd_MEM=3 with ALU_out_MEM=0x10, Rd_WB=3 with wb_data=0x20 -> forwarded operand is 0x10. Same case with Rs1=0 -> uses S1_EX.
REQ-042 BNEZ, S1=1, PC_EX=0x100, Iv=0x20 -> pc_cmd_EX=1 and pc_target_EX=0x120 in the same cycle. Same case with nullify=1 -> pc_cmd_EX=0 and a bubble goes to MEM.
REQ-043 MUL 0xFFFFFFFF*3 -> stall high 33 cycles, EX/MEM bubbles meanwhile, then ALU_out_MEM=0xFFFFFFFD for one commit.
REQ-044 reset_n low at BUSY cycle 10 -> next cycle stall=0, all EX/MEM outputs 0, no MUL commit.
REQ-045 SRA 0x80000000 by 4 -> 0xF8000000; SLTU 1,0xFFFFFFFF -> 1; SLT 1,0xFFFFFFFF -> 0.

Source files
------------

// File: rtl/ex_stage_if.sv
// EX stage bus: ID/EX register inputs, writeback feedback, and EX/MEM outputs.
interface ex_stage_if;
    logic        d_write_enable_EX, d_load_enable_EX, Iv_alu_EX, Pc_alu_EX, nullify;
    logic [4:0]  I_EX, Rd_EX, Rs1_EX, Rs2_EX;
    logic [31:0] Iv_EX, S1_EX, S2_EX, PC_EX;
    logic [4:0]  Rd_WB;
    logic [31:0] wb_data;
    logic        pc_cmd_EX;
    logic [31:0] pc_target_EX;
    logic        stall;
    logic        d_write_enable_MEM, d_load_enable_MEM;
    logic [4:0]  Rd_MEM;
    logic [31:0] ALU_out_MEM, S2_MEM;

    // Pipeline side driving the stage.
    modport master (
        output d_write_enable_EX, d_load_enable_EX, Iv_alu_EX, Pc_alu_EX, nullify,
               I_EX, Rd_EX, Rs1_EX, Rs2_EX, Iv_EX, S1_EX, S2_EX, PC_EX, Rd_WB, wb_data,
        input  pc_cmd_EX, pc_target_EX, stall, d_write_enable_MEM, d_load_enable_MEM,
               Rd_MEM, ALU_out_MEM, S2_MEM
    );

    // The EX stage itself.
    modport slave (
        input  d_write_enable_EX, d_load_enable_EX, Iv_alu_EX, Pc_alu_EX, nullify,
               I_EX, Rd_EX, Rs1_EX, Rs2_EX, Iv_EX, S1_EX, S2_EX, PC_EX, Rd_WB, wb_data,
        output pc_cmd_EX, pc_target_EX, stall, d_write_enable_MEM, d_load_enable_MEM,
               Rd_MEM, ALU_out_MEM, S2_MEM
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: forwarding, ALU, branch resolution, iterative 32-cycle
// shift-add multiplier with pipeline stall, and the EX/MEM register.
module ex_stage #(
    parameter bit MUL_EN = 1'b1
) (
    input logic       clk,
    input logic       reset_n,
    ex_stage_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
    // Destination info of the accepted MUL, held until its commit.
    logic [4:0]  mrd_q, mrd_d;
    logic        mwe_q, mwe_d, mle_q, mle_d;
    logic [31:0] ms2_q, ms2_d;
    // EX/MEM register.
    logic        we_q, we_d, le_q, le_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] alu_q, alu_d, s2_q, s2_d;

    logic [31:0] fwd1, fwd2, op_a, op_b, alu_res;
    logic        taken, valid, mul_start;

    // Operand forwarding; the MEM stage is younger so it wins over WB.
    always_comb begin
        fwd1 = bus.S1_EX;
        fwd2 = bus.S2_EX;
        if (bus.Rs1_EX != 5'd0 && rd_q == bus.Rs1_EX)            fwd1 = alu_q;
        else if (bus.Rs1_EX != 5'd0 && bus.Rd_WB == bus.Rs1_EX)  fwd1 = bus.wb_data;
        if (bus.Rs2_EX != 5'd0 && rd_q == bus.Rs2_EX)            fwd2 = alu_q;
        else if (bus.Rs2_EX != 5'd0 && bus.Rd_WB == bus.Rs2_EX)  fwd2 = bus.wb_data;
        op_a = bus.Pc_alu_EX ? bus.PC_EX : fwd1;
        op_b = bus.Iv_alu_EX ? bus.Iv_EX : fwd2;
    end

    // Single-cycle ALU and branch condition; MUL and unused codes give 0 here.
    always_comb begin
        alu_res = 32'd0;
        taken   = 1'b0;
        case (bus.I_EX)
            5'd0:  alu_res = op_a + op_b;
            5'd1:  alu_res = op_a - op_b;
            5'd2:  alu_res = op_a & op_b;
            5'd3:  alu_res = op_a | op_b;
            5'd4:  alu_res = op_a ^ op_b;
            5'd5:  alu_res = op_a << op_b[4:0];
            5'd6:  alu_res = op_a >> op_b[4:0];
            5'd7:  alu_res = $signed(op_a) >>> op_b[4:0];
            5'd8:  alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
            5'd9:  alu_res = {31'd0, op_a < op_b};
            5'd10: alu_res = {31'd0, op_a == op_b};
            5'd11: alu_res = {31'd0, op_a != op_b};
            5'd12: begin alu_res = bus.PC_EX + 32'd4; taken = (fwd1 == 32'd0); end
            5'd13: begin alu_res = bus.PC_EX + 32'd4; taken = (fwd1 != 32'd0); end
            5'd14: begin alu_res = bus.PC_EX + 32'd4; taken = 1'b1; end
            default: alu_res = 32'd0;
        endcase
    end

    assign valid            = !bus.nullify;
    assign mul_start        = MUL_EN && valid && (bus.I_EX == 5'd15) && (state_q == IDLE);
    assign bus.stall        = mul_start || (state_q == BUSY);
    assign bus.pc_cmd_EX    = taken && valid && !bus.stall;
    assign bus.pc_target_EX = bus.PC_EX + bus.Iv_EX;

    assign bus.d_write_enable_MEM = we_q;
    assign bus.d_load_enable_MEM  = le_q;
    assign bus.Rd_MEM             = rd_q;
    assign bus.ALU_out_MEM        = alu_q;
    assign bus.S2_MEM             = s2_q;

    // Multiplier FSM and EX/MEM next values; EX/MEM defaults to a bubble.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        mrd_d    = mrd_q;
        mwe_d    = mwe_q;
        mle_d    = mle_q;
        ms2_d    = ms2_q;
        we_d     = 1'b0;
        le_d     = 1'b0;
        rd_d     = 5'd0;
        alu_d    = 32'd0;
        s2_d     = 32'd0;
        case (state_q)
            IDLE: begin
                if (mul_start) begin
                    state_d  = BUSY;
                    cnt_d    = 5'd0;
                    acc_d    = 32'd0;
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    mrd_d    = bus.Rd_EX;
                    mwe_d    = bus.d_write_enable_EX;
                    mle_d    = bus.d_load_enable_EX;
                    ms2_d    = fwd2;
                end else if (valid) begin
                    we_d  = bus.d_write_enable_EX;
                    le_d  = bus.d_load_enable_EX;
                    rd_d  = bus.Rd_EX;
                    alu_d = alu_res;
                    s2_d  = fwd2;
                end
            end
            // nullify is not looked at: the held MUL was already accepted.
            BUSY: begin
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                we_d    = mwe_q;
                le_d    = mle_q;
                rd_d    = mrd_q;
                alu_d   = acc_q;
                s2_d    = ms2_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            acc_q    <= 32'd0;
            mcand_q  <= 32'd0;
            mplier_q <= 32'd0;
            mrd_q    <= 5'd0;
            mwe_q    <= 1'b0;
            mle_q    <= 1'b0;
            ms2_q    <= 32'd0;
            we_q     <= 1'b0;
            le_q     <= 1'b0;
            rd_q     <= 5'd0;
            alu_q    <= 32'd0;
            s2_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            mrd_q    <= mrd_d;
            mwe_q    <= mwe_d;
            mle_q    <= mle_d;
            ms2_q    <= ms2_d;
            we_q     <= we_d;
            le_q     <= le_d;
            rd_q     <= rd_d;
            alu_q    <= alu_d;
            s2_q     <= s2_d;
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU ops, forwarding, branches, multiplier
// stall/commit, reset abort, and the multiplier-disabled variant.
module tb_ex_stage;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    ex_stage_if bus ();
    ex_stage_if bus0 ();

    ex_stage dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    ex_stage #(.MUL_EN(1'b0)) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_instr(input int i, input int rs1, input logic [31:0] s1,
                             input int rs2, input logic [31:0] s2, input int rd);
        bus.I_EX              = 5'(i);
        bus.Rs1_EX            = 5'(rs1);
        bus.S1_EX             = s1;
        bus.Rs2_EX            = 5'(rs2);
        bus.S2_EX             = s2;
        bus.Rd_EX             = 5'(rd);
        bus.d_write_enable_EX = 1'b1;
        bus.d_load_enable_EX  = 1'b0;
        bus.Iv_alu_EX         = 1'b0;
        bus.Pc_alu_EX         = 1'b0;
        bus.Iv_EX             = 32'd0;
        bus.PC_EX             = 32'd0;
        bus.nullify           = 1'b0;
        bus.Rd_WB             = 5'd0;
        bus.wb_data           = 32'd0;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_alu"}, bus.ALU_out_MEM, 32'd0);
        chk({tag, "_rd"}, 32'(bus.Rd_MEM), 32'd0);
        chk({tag, "_we"}, 32'(bus.d_write_enable_MEM), 32'd0);
        chk({tag, "_le"}, 32'(bus.d_load_enable_MEM), 32'd0);
        chk({tag, "_s2"}, bus.S2_MEM, 32'd0);
    endtask

    task automatic mul_run(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input int rd, input bit null_mid);
        int n = 0;
        int bad = 0;
        set_instr(15, 0, a, 0, b, rd);
        #1;
        while (bus.stall && n < 40) begin
            n++;
            if (null_mid && n == 6) bus.nullify = 1'b1;
            tick();
            if (bus.ALU_out_MEM !== 32'd0 || bus.d_write_enable_MEM !== 1'b0 || bus.Rd_MEM !== 5'd0)
                bad++;
        end
        chk({tag, "_stall_cycles"}, 32'(n), 32'd33);
        chk({tag, "_bubbles"}, 32'(bad), 32'd0);
        tick();
        chk({tag, "_prod"}, bus.ALU_out_MEM, exp);
        chk({tag, "_rd"}, 32'(bus.Rd_MEM), 32'(rd));
        chk({tag, "_we"}, 32'(bus.d_write_enable_MEM), 32'd1);
        bus.nullify = 1'b1;
        tick();
        chk({tag, "_no_dup"}, 32'(bus.d_write_enable_MEM), 32'd0);
    endtask

    initial begin
        int bad;
        set_instr(0, 0, 0, 0, 0, 0);
        bus.nullify = 1'b1;
        bus0.I_EX = 5'd15; bus0.Rs1_EX = 5'd0; bus0.Rs2_EX = 5'd0; bus0.Rd_EX = 5'd2;
        bus0.S1_EX = 32'd6; bus0.S2_EX = 32'd7; bus0.Iv_EX = 32'd0; bus0.PC_EX = 32'd0;
        bus0.d_write_enable_EX = 1'b1; bus0.d_load_enable_EX = 1'b0;
        bus0.Iv_alu_EX = 1'b0; bus0.Pc_alu_EX = 1'b0; bus0.nullify = 1'b1;
        bus0.Rd_WB = 5'd0; bus0.wb_data = 32'd0;

        // Reset state
        tick(); tick();
        chk_bubble("reset");
        chk("reset_stall", 32'(bus.stall), 32'd0);
        chk("reset_pc_cmd", 32'(bus.pc_cmd_EX), 32'd0);
        reset_n = 1'b1;

        // ADD 5+7, first instruction after reset
        set_instr(0, 1, 5, 2, 7, 9);
        tick();
        chk("add_alu", bus.ALU_out_MEM, 32'd12);
        chk("add_rd", 32'(bus.Rd_MEM), 32'd9);
        chk("add_we", 32'(bus.d_write_enable_MEM), 32'd1);
        chk("add_s2", bus.S2_MEM, 32'd7);

        // Forwarding: MEM beats WB on the same register
        set_instr(0, 0, 32'h10, 0, 0, 3);
        tick();
        chk("fwd_prod", bus.ALU_out_MEM, 32'h10);
        set_instr(3, 3, 32'hAAAA, 0, 0, 3);
        bus.Rd_WB = 5'd3; bus.wb_data = 32'h20;
        tick();
        chk("fwd_mem_prio", bus.ALU_out_MEM, 32'h10);
        // Rs1=0 never forwards
        set_instr(0, 0, 32'h5, 0, 0, 6);
        bus.Rd_WB = 5'd3; bus.wb_data = 32'h20;
        tick();
        chk("fwd_rs0", bus.ALU_out_MEM, 32'h5);
        // WB forward on Rs1, MEM forward on Rs2 (also shows up in S2_MEM)
        set_instr(0, 3, 32'hAAAA, 6, 32'h1000, 7);
        bus.Rd_WB = 5'd3; bus.wb_data = 32'h20;
        tick();
        chk("fwd_wb_mem", bus.ALU_out_MEM, 32'h25);
        chk("fwd_s2", bus.S2_MEM, 32'h5);

        // BNEZ taken, then the same nullified
        set_instr(13, 0, 1, 0, 0, 0);
        bus.d_write_enable_EX = 1'b0; bus.PC_EX = 32'h100; bus.Iv_EX = 32'h20;
        #1;
        chk("bnez_cmd", 32'(bus.pc_cmd_EX), 32'd1);
        chk("bnez_target", bus.pc_target_EX, 32'h120);
        tick();
        chk("bnez_link", bus.ALU_out_MEM, 32'h104);
        bus.nullify = 1'b1; bus.Rd_EX = 5'd7; bus.d_write_enable_EX = 1'b1;
        #1;
        chk("bnez_null_cmd", 32'(bus.pc_cmd_EX), 32'd0);
        tick();
        chk_bubble("bnez_null");
        // BEQZ on nonzero: not taken; J: always taken
        set_instr(12, 0, 1, 0, 0, 0);
        #1;
        chk("beqz_nt", 32'(bus.pc_cmd_EX), 32'd0);
        bus.I_EX = 5'd14;
        #1;
        chk("j_cmd", 32'(bus.pc_cmd_EX), 32'd1);
        tick();

        // Shifts and compares
        set_instr(7, 0, 32'h80000000, 0, 0, 1);
        bus.Iv_alu_EX = 1'b1; bus.Iv_EX = 32'd4;
        tick();
        chk("sra", bus.ALU_out_MEM, 32'hF8000000);
        set_instr(5, 0, 1, 0, 0, 1);
        bus.Iv_alu_EX = 1'b1; bus.Iv_EX = 32'h21;
        tick();
        chk("sll_amt5", bus.ALU_out_MEM, 32'd2);
        set_instr(9, 0, 1, 0, 32'hFFFFFFFF, 1);
        tick();
        chk("sltu", bus.ALU_out_MEM, 32'd1);
        set_instr(8, 0, 1, 0, 32'hFFFFFFFF, 1);
        tick();
        chk("slt", bus.ALU_out_MEM, 32'd0);
        set_instr(1, 0, 3, 0, 5, 1);
        tick();
        chk("sub_wrap", bus.ALU_out_MEM, 32'hFFFFFFFE);
        set_instr(10, 0, 5, 0, 5, 1);
        tick();
        chk("seq", bus.ALU_out_MEM, 32'd1);
        set_instr(20, 0, 5, 0, 5, 1);
        tick();
        chk("undef_op", bus.ALU_out_MEM, 32'd0);

        // Multiplier
        mul_run("mul_ff3", 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFD, 5, 1'b0);
        mul_run("mul_min", 32'h80000000, 32'h80000000, 32'd0, 8, 1'b1);
        mul_run("mul_mix", 32'h12345678, 32'h10, 32'h23456780, 9, 1'b0);

        // Reset in BUSY cycle 10 aborts the multiply
        set_instr(15, 0, 32'd7, 0, 32'd6, 4);
        #1;
        tick();
        repeat (10) tick();
        chk("busy_stall", 32'(bus.stall), 32'd1);
        reset_n = 1'b0;
        bus.nullify = 1'b1;
        tick();
        reset_n = 1'b1;
        chk("rst_busy_stall", 32'(bus.stall), 32'd0);
        chk("rst_busy_pc_cmd", 32'(bus.pc_cmd_EX), 32'd0);
        chk_bubble("rst_busy");
        bad = 0;
        repeat (40) begin
            tick();
            if (bus.d_write_enable_MEM !== 1'b0) bad++;
        end
        chk("rst_no_commit", 32'(bad), 32'd0);
        set_instr(0, 0, 2, 0, 3, 11);
        tick();
        chk("post_rst_add", bus.ALU_out_MEM, 32'd5);

        // Multiplier disabled: I=15 is a one-cycle zero result
        bus0.nullify = 1'b0;
        #1;
        chk("nomul_stall", 32'(bus0.stall), 32'd0);
        tick();
        chk("nomul_res", bus0.ALU_out_MEM, 32'd0);
        chk("nomul_rd", 32'(bus0.Rd_MEM), 32'd2);
        chk("nomul_we", 32'(bus0.d_write_enable_MEM), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
